// File: rtl/rr_grant_pkg.sv
// Shared constants and state encoding for the 16-way round-robin grant controller.
package rr_grant_pkg;

    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick_16.sv
// Rotating priority encoder: first asserted request after i_last_idx, wrapping 15->0;
// i_last_idx itself is the lowest priority.
module rr_pick_16
    import rr_grant_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = i_last_idx;
        w_cand  = '0;
        // Walk from farthest offset to nearest so the nearest hit wins; offset 16 is i_last_idx.
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = i_last_idx + IDX_W'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl_16.sv
// Round-robin arbiter for one 16-slot resource: bounded hold, one-cycle break-before-make gap.
// Optional macro LOCK_EN adds a 'lock' input that freezes the hold timer and suppresses timeout.
//   state | meaning
//   IDLE  | no grant; pick when en=1 and any req
//   GRANT | gnt_idx owns the resource; hold timer runs
//   GAP   | one cycle with no grant; last_idx = previous holder; pick again
module rr_grant_ctrl_16
    import rr_grant_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef LOCK_EN
    input  logic             lock,
`endif
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam bit                TIMEOUT_EN = (HOLD_MAX != 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = (HOLD_MAX == 0) ? '0 : HOLD_W'(HOLD_MAX - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NREQ-1:0]    r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_valid;
    logic               r_preempt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [IDX_W-1:0]   r_last_idx;

    logic [NREQ-1:0]    w_gnt_nxt;
    logic [IDX_W-1:0]   w_gnt_idx_nxt;
    logic               w_gnt_valid_nxt;
    logic               w_preempt_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [IDX_W-1:0]   w_last_nxt;

    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_can_pick;
    logic               w_lock;
    logic [NREQ-1:0]    w_holder_mask;
    logic               w_holder_req;
    logic               w_others;
    logic               w_timeout;
    logic               w_release;
    logic               w_preempt_go;

    rr_pick_16 u_pick (
        .i_req      (req),
        .i_last_idx (r_last_idx),
        .o_found    (w_pick_found),
        .o_idx      (w_pick_idx)
    );

`ifdef LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_can_pick    = en && w_pick_found;
    assign w_holder_mask = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt_idx;
    assign w_holder_req  = req[r_gnt_idx];
    assign w_others      = |(req & ~w_holder_mask);
    // Compare against HOLD_MAX-1 with >= so a saturated timer still preempts a late arrival.
    assign w_timeout     = TIMEOUT_EN && !w_lock && (r_hold_cnt >= HOLD_LAST);
    assign w_release     = !w_holder_req;
    assign w_preempt_go  = w_holder_req && w_timeout && w_others;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_can_pick ? GRANT : IDLE;
            GRANT:   w_state_nxt = (w_release || w_preempt_go) ? GAP : GRANT;
            GAP:     w_state_nxt = w_can_pick ? GRANT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = 1'b0;
        w_preempt_nxt   = 1'b0;
        w_hold_nxt      = r_hold_cnt;
        w_last_nxt      = r_last_idx;
        w_gnt_nxt       = '0;
        case (r_state)
            IDLE, GAP: begin
                if (w_can_pick) begin
                    w_gnt_idx_nxt   = w_pick_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = '0;
                end
            end
            GRANT: begin
                if (w_release || w_preempt_go) begin
                    w_preempt_nxt = w_preempt_go;
                    w_last_nxt    = r_gnt_idx;
                end else begin
                    w_gnt_valid_nxt = 1'b1;
                    if (!w_lock && (r_hold_cnt < HOLD_SAT)) begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
        for (int i = 0; i < NREQ; i++) begin
            w_gnt_nxt[i] = w_gnt_valid_nxt && (w_gnt_idx_nxt == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= IDX_W'(NREQ - 1);
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_preempt   <= w_preempt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_last_idx  <= w_last_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_grant_ctrl_16.sv
// Bench for rr_grant_ctrl_16 (HOLD_MAX=4): cycle model of the arbitration rules plus literal spot checks.
module tb_rr_grant_ctrl_16;

    localparam int HM = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        lock  = 1'b0;
    logic [15:0] req   = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: current holder (-1 = none), last holder, cycles held, visible index, preempt pulse.
    int m_holder = -1;
    int m_last   = 15;
    int m_cycles = 0;
    int m_idx    = 0;
    bit m_pre    = 1'b0;
    bit m_others = 1'b0;
    int m_p      = -1;

    logic [15:0] vec_req [8] = '{16'h00F0, 16'h0F00, 16'h1234, 16'h0000,
                                 16'h8001, 16'hA5A5, 16'h0010, 16'hFFFF};
    int          vec_len [8] = '{7, 9, 12, 3, 6, 15, 5, 10};
    bit          vec_en  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rr_grant_ctrl_16 #(.HOLD_MAX(HM), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
`ifdef LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [15:0] r, input int last);
        for (int off = 1; off <= 16; off++) begin
            if (r[(last + off) % 16]) return (last + off) % 16;
        end
        return -1;
    endfunction

    // Model advances on each rising edge from the inputs present at that edge.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_holder = -1; m_last = 15; m_cycles = 0; m_idx = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_holder >= 0) begin
                m_others = |(req & ~(16'h0001 << m_holder));
                if (!lock) m_cycles++;
                if (!req[m_holder]) begin
                    m_last = m_holder; m_holder = -1;
                end else if (!lock && m_cycles >= HM && m_others) begin
                    m_last = m_holder; m_holder = -1; m_pre = 1'b1;
                end
            end else begin
                m_p = en ? pick(req, m_last) : -1;
                if (m_p >= 0) begin
                    m_holder = m_p; m_idx = m_p; m_cycles = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("gnt", 32'(gnt), (m_holder >= 0) ? (32'h1 << m_holder) : 32'h0);
            check("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
            check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
            check("preempt", 32'(preempt), 32'(m_pre));
            check("onehot_inv", 32'(($countones(gnt) <= 1) && (gnt_valid || gnt == 16'h0)), 32'h1);
        end
    end

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; en = 1'b1; lock = 1'b0;
        nxt(2);
        rst_n = 1'b1;
    endtask

    int seen;

    initial begin
        // Reset state, then single request
        do_reset();
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        req = 16'h0001;
        nxt(1);
        check("first_gnt", 32'(gnt), 32'h0001);
        check("first_pre", 32'(preempt), 32'h0);

        // Index 0 before 15, then handover through one GAP
        do_reset();
        nxt(1);
        req = 16'h8001;
        nxt(1);
        check("s2_gnt0", 32'(gnt), 32'h0001);
        nxt(1);
        req = 16'h8000;
        nxt(1);
        check("s2_gap", 32'(gnt_valid), 32'h0);
        nxt(1);
        check("s2_gnt15", 32'(gnt), 32'h8000);
        nxt(3);

        // Alternating timeout between 1 and 2
        do_reset();
        req = 16'h0006;
        for (int i = 1; i <= 12; i++) begin
            nxt(1);
            case (i)
                1:  check("alt_g1a", 32'(gnt), 32'h0002);
                4:  check("alt_g1b", 32'(gnt), 32'h0002);
                5:  check("alt_pre1", 32'(preempt), 32'h1);
                6:  check("alt_g2", 32'(gnt), 32'h0004);
                10: check("alt_pre2", 32'(preempt), 32'h1);
                11: check("alt_g1c", 32'(gnt), 32'h0002);
                default: ;
            endcase
        end

        // Lone holder keeps grant past timeout; late arrival preempts
        do_reset();
        req = 16'h0020;
        nxt(20);
        check("lone_gnt", 32'(gnt), 32'h0020);
        req = 16'h0220;
        nxt(1);
        check("late_pre", 32'(preempt), 32'h1);
        nxt(1);
        check("late_gnt", 32'(gnt), 32'h0200);
        nxt(2);

        // en=0 blocks first grant; reset mid-grant; last_idx restored to 15
        do_reset();
        en = 1'b0;
        req = 16'hFFFF;
        nxt(5);
        check("en0_gnt", 32'(gnt), 32'h0);
        en = 1'b1;
        nxt(1);
        check("en1_gnt", 32'(gnt), 32'h0001);
        nxt(2);
        rst_n = 1'b0;
        nxt(1);
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_pre", 32'(preempt), 32'h0);
        rst_n = 1'b1;
        nxt(1);
        check("postrst_gnt", 32'(gnt), 32'h0001);
        nxt(2);

        // en dropped during grant: timeout still fires, no new grant afterwards
        do_reset();
        req = 16'h0003;
        nxt(1);
        check("en_g0", 32'(gnt), 32'h0001);
        en = 1'b0;
        nxt(4);
        check("en_pre", 32'(preempt), 32'h1);
        nxt(1);
        check("en_idle", 32'(gnt_valid), 32'h0);
        nxt(1);
        en = 1'b1;
        nxt(1);
        check("en_resume", 32'(gnt), 32'h0002);
        nxt(2);

        // Mixed directed vectors, model-checked every cycle
        for (int v = 0; v < 8; v++) begin
            req = vec_req[v];
            en  = vec_en[v];
            nxt(vec_len[v]);
        end

`ifdef LOCK_EN
        do_reset();
        lock = 1'b1;
        req  = 16'h0003;
        nxt(12);
        check("lock_hold", 32'(gnt), 32'h0001);
        lock = 1'b0;
        seen = 0;
        for (int i = 1; i <= 6; i++) begin
            nxt(1);
            if (seen == 0 && preempt) seen = i;
        end
        check("lock_release_pre", 32'(seen), 32'd4);
`endif

        chk_en = 1'b0;
        nxt(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
